// File: rtl/idu_fetch_rcv_pkg.sv
// Shared types and constants for the IDU fetch receiver: FSM states,
// interface widths and the buffered packet entry layout.
package idu_fetch_rcv_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned PKT_W = 64;
  localparam int unsigned PC_W  = 32;

  localparam logic [INS_W-1:0] WFI_ENC = 32'h10500073;

  typedef enum logic {
    IDU_FSM_RUN   = 1'b0,
    IDU_FSM_SLEEP = 1'b1
  } idu_fsm_e;

  // Packet pc is stored 8-byte aligned; lo_valid clears when pc[2] was set.
  typedef struct packed {
    logic [PKT_W-1:0] ins;
    logic [PC_W-4:0]  pc;
    logic             lo_valid;
  } idu_pkt_t;

endpackage

// File: rtl/idu_pkt_fifo.sv
// Registered packet FIFO for the fetch receiver; flush empties it in one cycle
// and takes priority over push and pop.
module idu_pkt_fifo
  import idu_fetch_rcv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  idu_pkt_t                 din_i,
  output idu_pkt_t                 head_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  idu_pkt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok, pop_ok, empty;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/idu_fetch_rcv.sv
// IDU fetch receiver: buffers 64-bit fetch packets and issues one 32-bit
// instruction per cycle, with branch flush and WFI sleep/wake handling.
module idu_fetch_rcv
  import idu_fetch_rcv_pkg::*;
#(
  parameter int unsigned      DEPTH   = 2,
  parameter logic [INS_W-1:0] WFI_INS = WFI_ENC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_idu_vld,
  input  logic [PKT_W-1:0]  ifu_idu_ins,
  input  logic [PC_W-1:0]   ifu_idu_pc,
  output logic              idu_ifu_rdy,
  output logic              idu_ifu_wfi,
  input  logic              alu_idu_br_vld,
  input  logic              irq_wake,
  input  logic              dec_idu_rdy,
  output logic              idu_dec_vld,
  output logic [INS_W-1:0]  idu_dec_ins,
  output logic [PC_W-1:0]   idu_dec_pc
);

  localparam int unsigned AW = $clog2(DEPTH);

  idu_fsm_e          state_q, state_d;
  logic              slot_q, slot_d;
  logic              wfi_q, wfi_d;

  idu_pkt_t          pkt_in, head;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_cnt;
  logic              push, pop, fifo_flush;

  logic              run, eff_slot, issue, wfi_hit;
  logic [INS_W-1:0]  sel_ins;
  logic [PC_W-1:0]   sel_pc;
  logic              pc_lsb_unused;

  assign pc_lsb_unused = &{1'b0, ifu_idu_pc[1:0]};

  assign pkt_in = {ifu_idu_ins, ifu_idu_pc[PC_W-1:3], ~ifu_idu_pc[2]};

  assign run        = (state_q == IDU_FSM_RUN);
  assign fifo_empty = (fifo_cnt == '0);

  // A head packet whose low slot is invalid is issued from slot 1 directly.
  assign eff_slot = slot_q | ~head.lo_valid;
  assign sel_ins  = eff_slot ? head.ins[2*INS_W-1:INS_W] : head.ins[INS_W-1:0];
  assign sel_pc   = {head.pc, eff_slot, 2'b00};

  assign idu_dec_vld = run & ~fifo_empty;
  assign idu_dec_ins = idu_dec_vld ? sel_ins : '0;
  assign idu_dec_pc  = idu_dec_vld ? sel_pc  : '0;

  assign idu_ifu_rdy = run & ~fifo_full & ~alu_idu_br_vld;
  assign idu_ifu_wfi = wfi_q;

  assign issue      = idu_dec_vld & dec_idu_rdy;
  assign wfi_hit    = issue & (sel_ins == WFI_INS) & ~alu_idu_br_vld;
  assign push       = ifu_idu_vld & idu_ifu_rdy;
  assign pop        = issue & eff_slot;
  assign fifo_flush = alu_idu_br_vld | wfi_hit;

  idu_pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (fifo_flush),
    .din_i   (pkt_in),
    .head_o  (head),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDU_FSM_RUN:   if (wfi_hit) state_d = IDU_FSM_SLEEP;
      IDU_FSM_SLEEP: if (irq_wake | alu_idu_br_vld) state_d = IDU_FSM_RUN;
      default:       state_d = IDU_FSM_RUN;
    endcase
    if (fifo_flush)  slot_d = 1'b0;
    else if (issue)  slot_d = ~eff_slot;
    wfi_d = (state_d == IDU_FSM_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDU_FSM_RUN;
      slot_q  <= 1'b0;
      wfi_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wfi_q   <= wfi_d;
    end
  end

endmodule

// File: tb/tb_idu_fetch_rcv.sv
// Directed bench for idu_fetch_rcv: per-cycle vector table plus hand-written
// backpressure and reset sequences.
module tb_idu_fetch_rcv;

  localparam logic [31:0] WFI = 32'h10500073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_idu_vld;
  logic [63:0] ifu_idu_ins;
  logic [31:0] ifu_idu_pc;
  logic        idu_ifu_rdy;
  logic        idu_ifu_wfi;
  logic        alu_idu_br_vld;
  logic        irq_wake;
  logic        dec_idu_rdy;
  logic        idu_dec_vld;
  logic [31:0] idu_dec_ins;
  logic [31:0] idu_dec_pc;

  int checks = 0;
  int errors = 0;

  idu_fetch_rcv #(
    .DEPTH   (2),
    .WFI_INS (WFI)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_idu_vld    (ifu_idu_vld),
    .ifu_idu_ins    (ifu_idu_ins),
    .ifu_idu_pc     (ifu_idu_pc),
    .idu_ifu_rdy    (idu_ifu_rdy),
    .idu_ifu_wfi    (idu_ifu_wfi),
    .alu_idu_br_vld (alu_idu_br_vld),
    .irq_wake       (irq_wake),
    .dec_idu_rdy    (dec_idu_rdy),
    .idu_dec_vld    (idu_dec_vld),
    .idu_dec_ins    (idu_dec_ins),
    .idu_dec_pc     (idu_dec_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] ins;
    logic [31:0] pc;
    logic        br;
    logic        wake;
    logic        drdy;
    logic        e_rdy;
    logic        e_wfi;
    logic        e_dvld;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(input logic v, input logic [63:0] ins, input logic [31:0] pc,
                              input logic br, input logic wk, input logic dr,
                              input logic er, input logic ew, input logic ed,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.vld = v; t.ins = ins; t.pc = pc; t.br = br; t.wake = wk; t.drdy = dr;
    t.e_rdy = er; t.e_wfi = ew; t.e_dvld = ed; t.e_ins = ei; t.e_pc = ep;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] ins, input logic [31:0] pc,
                       input logic br, input logic wk, input logic dr);
    ifu_idu_vld    = v;
    ifu_idu_ins    = ins;
    ifu_idu_pc     = pc;
    alu_idu_br_vld = br;
    irq_wake       = wk;
    dec_idu_rdy    = dr;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_ins [6];
    logic [31:0] exp_pc  [6];
    int          n_iss;
    logic        pending;
    logic        took;

    // pkt 0x100/0x204/0x208: basic issue and odd-pc start
    vt[0]  = mk(1, {32'h22, 32'h11}, 32'h100, 0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[1]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, 32'h11, 32'h100);
    vt[2]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, 32'h22, 32'h104);
    vt[3]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[4]  = mk(1, {32'hBB, 32'hAA}, 32'h204, 0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[5]  = mk(1, {32'hDD, 32'hCC}, 32'h208, 0, 0, 1,  1, 1, 1, 32'hBB, 32'h204);
    vt[6]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, 32'hCC, 32'h208);
    vt[7]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, 32'hDD, 32'h20C);
    vt[8]  = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    // full FIFO with slot=1, then branch flush with a packet offered
    vt[9]  = mk(1, {32'h2, 32'h1}, 32'h300,   0, 0, 0,  1, 1, 0, 32'h0,  32'h0);
    vt[10] = mk(1, {32'h4, 32'h3}, 32'h308,   0, 0, 1,  1, 1, 1, 32'h1,  32'h300);
    vt[11] = mk(1, {32'h6, 32'h5}, 32'h310,   1, 0, 0,  0, 1, 1, 32'h2,  32'h304);
    vt[12] = mk(1, {32'h8, 32'h7}, 32'h318,   0, 0, 0,  1, 1, 0, 32'h0,  32'h0);
    vt[13] = mk(0, 64'h0, 32'h0,              0, 0, 0,  1, 1, 1, 32'h7,  32'h318);
    vt[14] = mk(0, 64'h0, 32'h0,              1, 0, 0,  0, 1, 1, 32'h7,  32'h318);
    vt[15] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    // WFI sleep, irq wake
    vt[16] = mk(1, {32'h13, WFI}, 32'h400,    0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[17] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, WFI,    32'h400);
    vt[18] = mk(1, {32'h13, 32'h13}, 32'h408, 0, 0, 1,  0, 0, 0, 32'h0,  32'h0);
    vt[19] = mk(0, 64'h0, 32'h0,              0, 1, 1,  0, 0, 0, 32'h0,  32'h0);
    vt[20] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    // flush and WFI issue together: stay awake
    vt[21] = mk(1, {32'h13, WFI}, 32'h500,    0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[22] = mk(0, 64'h0, 32'h0,              1, 0, 1,  0, 1, 1, WFI,    32'h500);
    vt[23] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    // WFI sleep, branch wake
    vt[24] = mk(1, {32'h13, WFI}, 32'h600,    0, 0, 1,  1, 1, 0, 32'h0,  32'h0);
    vt[25] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 1, WFI,    32'h600);
    vt[26] = mk(0, 64'h0, 32'h0,              1, 0, 1,  0, 0, 0, 32'h0,  32'h0);
    vt[27] = mk(0, 64'h0, 32'h0,              0, 0, 1,  1, 1, 0, 32'h0,  32'h0);

    rst_n = 1'b0;
    drive(0, 64'h0, 32'h0, 0, 0, 1);
    #1;
    chk("rst_dvld", 32'(idu_dec_vld), 32'h0);
    chk("rst_ins",  idu_dec_ins, 32'h0);
    chk("rst_pc",   idu_dec_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(idu_ifu_rdy), 32'h1);
    chk("rst_wfi", 32'(idu_ifu_wfi), 32'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].vld, vt[i].ins, vt[i].pc, vt[i].br, vt[i].wake, vt[i].drdy);
      #1;
      chk($sformatf("v%0d_rdy", i),  32'(idu_ifu_rdy), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_wfi", i),  32'(idu_ifu_wfi), 32'(vt[i].e_wfi));
      chk($sformatf("v%0d_dvld", i), 32'(idu_dec_vld), 32'(vt[i].e_dvld));
      chk($sformatf("v%0d_ins", i),  idu_dec_ins, vt[i].e_ins);
      chk($sformatf("v%0d_pc", i),   idu_dec_pc, vt[i].e_pc);
    end

    // Backpressure: third packet held until a pop frees an entry; order kept.
    @(negedge clk);
    drive(1, {32'hA1, 32'hA0}, 32'h700, 0, 0, 0);
    #1 chk("bp_rdy_p0", 32'(idu_ifu_rdy), 32'h1);
    @(negedge clk);
    drive(1, {32'hA3, 32'hA2}, 32'h708, 0, 0, 0);
    #1 chk("bp_rdy_p1", 32'(idu_ifu_rdy), 32'h1);
    @(negedge clk);
    drive(1, {32'hA5, 32'hA4}, 32'h710, 0, 0, 0);
    #1 chk("bp_rdy_full", 32'(idu_ifu_rdy), 32'h0);
    repeat (2) @(negedge clk);
    #1 chk("bp_rdy_held", 32'(idu_ifu_rdy), 32'h0);

    exp_ins = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    exp_pc  = '{32'h700, 32'h704, 32'h708, 32'h70C, 32'h710, 32'h714};
    n_iss   = 0;
    pending = 1'b1;
    dec_idu_rdy = 1'b1;
    for (int c = 0; c < 20 && n_iss < 6; c++) begin
      #1;
      took = pending & idu_ifu_rdy;
      if (idu_dec_vld) begin
        chk($sformatf("bp_ins%0d", n_iss), idu_dec_ins, exp_ins[n_iss]);
        chk($sformatf("bp_pc%0d", n_iss),  idu_dec_pc,  exp_pc[n_iss]);
        n_iss++;
      end
      @(negedge clk);
      if (took) begin
        pending = 1'b0;
        ifu_idu_vld = 1'b0;
      end
    end
    chk("bp_issued", 32'(n_iss), 32'd6);

    // Reset mid-stream with a full FIFO.
    @(negedge clk);
    drive(1, {32'hB1, 32'hB0}, 32'h800, 0, 0, 0);
    @(negedge clk);
    drive(1, {32'hB3, 32'hB2}, 32'h808, 0, 0, 0);
    @(negedge clk);
    drive(0, 64'h0, 32'h0, 0, 0, 0);
    #1 chk("mr_full_rdy", 32'(idu_ifu_rdy), 32'h0);
    chk("mr_full_dvld", 32'(idu_dec_vld), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mr_dvld", 32'(idu_dec_vld), 32'h0);
    chk("mr_ins", idu_dec_ins, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_rdy", 32'(idu_ifu_rdy), 32'h1);
    chk("mr_wfi", 32'(idu_ifu_wfi), 32'h1);
    chk("mr_empty", 32'(idu_dec_vld), 32'h0);

    // Reset while asleep restores the fetch hint.
    @(negedge clk);
    drive(1, {32'h13, WFI}, 32'h900, 0, 0, 1);
    @(negedge clk);
    drive(0, 64'h0, 32'h0, 0, 0, 1);
    @(negedge clk);
    #1 chk("ms_wfi0", 32'(idu_ifu_wfi), 32'h0);
    rst_n = 1'b0;
    #1 chk("ms_wfi_rst", 32'(idu_ifu_wfi), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ms_rdy", 32'(idu_ifu_rdy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
